// File: rtl/mul8_seq_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul8_seq_sched
// Brief    : 8x8 multiply over one shared 4x4 core, nibble steps LL,LH,HL,HH.
// Revision : 1.0 - initial release
// ============================================================================
module mul8_seq_sched #(
    parameter bit TRUNC_LL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_en,
    input  logic [7:0]  mul_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod16,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_LL = 3'd1,
        S_LH = 3'd2,
        S_HL = 3'd3,
        S_HH = 3'd4,
        DONE = 3'd5
    } state_t;

    // The truncated variant drops the LL step entirely.
    localparam state_t c_first_step = TRUNC_LL ? S_LH : S_LL;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_al;
    logic [3:0]  r_ah;
    logic [3:0]  r_bl;
    logic [3:0]  r_bh;
    logic [15:0] r_acc;
    logic [15:0] w_addend;
    logic        w_accept;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign prod16    = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mul_a       = 4'h0;
        mul_b       = 4'h0;
        mul_en      = 1'b0;
        w_addend    = 16'h0000;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = c_first_step;
            end
            S_LL: begin
                mul_a       = r_al;
                mul_b       = r_bl;
                mul_en      = 1'b1;
                w_addend    = {8'h00, mul_prod};
                w_state_nxt = S_LH;
            end
            S_LH: begin
                mul_a       = r_al;
                mul_b       = r_bh;
                mul_en      = 1'b1;
                w_addend    = {4'h0, mul_prod, 4'h0};
                w_state_nxt = S_HL;
            end
            S_HL: begin
                mul_a       = r_ah;
                mul_b       = r_bl;
                mul_en      = 1'b1;
                w_addend    = {4'h0, mul_prod, 4'h0};
                w_state_nxt = S_HH;
            end
            S_HH: begin
                mul_a       = r_ah;
                mul_b       = r_bh;
                mul_en      = 1'b1;
                w_addend    = {mul_prod, 8'h00};
                w_state_nxt = DONE;
            end
            DONE: begin
                // Back-to-back accept overlaps the result handshake.
                if (out_ready) w_state_nxt = w_accept ? c_first_step : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sum wraps modulo 2^16; an approximate core may overflow the true product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_al  <= 4'h0;
            r_ah  <= 4'h0;
            r_bl  <= 4'h0;
            r_bh  <= 4'h0;
            r_acc <= 16'h0000;
        end else if (w_accept) begin
            r_al  <= a[3:0];
            r_ah  <= a[7:4];
            r_bl  <= b[3:0];
            r_bh  <= b[7:4];
            r_acc <= 16'h0000;
        end else if (mul_en) begin
            r_acc <= r_acc + w_addend;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul8_seq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul8_seq_sched
// Brief    : Scoreboard bench for the exact and LL-truncated scheduler variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul8_seq_sched;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  iv, ir, me, ov, orr, busy;
    logic [7:0]  av [2];
    logic [7:0]  bv [2];
    logic [7:0]  mp [2];
    logic [3:0]  ma [2];
    logic [3:0]  mb [2];
    logic [15:0] p  [2];
    bit          force_ff;
    bit          rnd_rdy;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul8_seq_sched #(.TRUNC_LL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0]), .b(bv[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_en(me[0]),
        .mul_prod(mp[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .prod16(p[0]), .busy(busy[0])
    );

    mul8_seq_sched #(.TRUNC_LL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_en(me[1]),
        .mul_prod(mp[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .prod16(p[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: true product, minus the LL term when truncated; a core stuck
    // at 0xFF contributes 0xFF at each step's weight.
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                             input bit trunc, input bit ff);
        int unsigned s;
        if (ff) s = (trunc ? 0 : 255) + 2 * 255 * 16 + 255 * 256;
        else    s = int'(x) * int'(y) - (trunc ? int'(x % 16) * int'(y % 16) : 0);
        return s[15:0];
    endfunction

    function automatic logic [7:0] exp_nib(input logic [7:0] x, input logic [7:0] y, input int i);
        case (i)
            0:       return {x[3:0], y[3:0]};
            1:       return {x[3:0], y[7:4]};
            2:       return {x[7:4], y[3:0]};
            default: return {x[7:4], y[7:4]};
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_core
        assign mp[k] = force_ff ? 8'hFF : {4'h0, ma[k]} * {4'h0, mb[k]};
    end

    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam int LAT = (k == 0) ? 5 : 4;
        localparam int NST = (k == 0) ? 4 : 3;
        exp_t       sb   [$];
        logic [7:0] seen [$];
        bit         waiting;

        always @(negedge clk) begin
            if (!rst_n) begin
                waiting = 1'b0;
                seen.delete();
            end else begin
                if (me[k]) seen.push_back({ma[k], mb[k]});
                if (!busy[k] || ov[k]) chk("mul_idle", {23'h0, me[k], ma[k], mb[k]}, 32'h0);
                if (ov[k]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {31'h0, ov[k]}, 32'h0);
                    end else begin
                        chk("prod16", p[k], sb[0].p);
                        chk("in_ready_done", ir[k], orr[k]);
                        if (!waiting) begin
                            chk("latency", cyc - sb[0].t, LAT);
                            chk("steps", seen.size(), NST);
                            for (int i = 0; i < seen.size() && i < NST; i++)
                                chk("nibbles", seen[i], exp_nib(sb[0].a, sb[0].b, i + 4 - NST));
                        end
                        if (orr[k]) begin
                            void'(sb.pop_front());
                            waiting = 1'b0;
                            seen.delete();
                        end else begin
                            waiting = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   n;
        iv[k] = 1'b1;
        av[k] = x;
        bv[k] = y;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir[k]) break;
            if (++n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        e = '{a: x, b: y, p: ref_prod(x, y, k == 1, force_ff), t: cyc};
        if (k == 0) g_mon[0].sb.push_back(e);
        else        g_mon[1].sb.push_back(e);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((busy[k] || (k == 0 ? g_mon[0].sb.size() : g_mon[1].sb.size()) != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'h0, busy[k]}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        iv       = 2'b00;
        orr      = 2'b11;
        av[0]    = 8'h00; av[1] = 8'h00;
        bv[0]    = 8'h00; bv[1] = 8'h00;
        force_ff = 1'b0;
        rnd_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", {31'h0, ir[k]}, 32'h1);
            chk("rst_busy", {31'h0, busy[k]}, 32'h0);
            chk("rst_out_valid", {31'h0, ov[k]}, 32'h0);
            chk("rst_prod16", p[k], 32'h0);
            chk("rst_mul", {23'h0, me[k], ma[k], mb[k]}, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: corner operands, back-to-back, truncated variant
        send(0, 8'hFF, 8'hFF);
        send(0, 8'h12, 8'h34);
        send(1, 8'h0F, 8'h0F);
        send(1, 8'hFF, 8'hFF);
        wait_idle(0);
        wait_idle(1);

        // Core stuck at 0xFF exercises 16-bit wrap
        force_ff = 1'b1;
        send(0, 8'($urandom), 8'($urandom));
        send(1, 8'($urandom), 8'($urandom));
        wait_idle(0);
        wait_idle(1);
        force_ff = 1'b0;

        // Backpressure: hold result three cycles, then same-cycle accept
        orr[0] = 1'b0;
        send(0, 8'h5A, 8'hC3);
        for (int n = 0; n < 50 && !ov[0]; n++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'h0, ov[0]}, 32'h1);
            chk("bp_in_ready", {31'h0, ir[0]}, 32'h0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        orr[0] = 1'b1;
        send(0, 8'hA7, 8'h3E);
        wait_idle(0);

        // Reset while in S_HL discards the operation
        send(0, 8'hAB, 8'hCD);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("hl_mul_a", {28'h0, ma[0]}, 32'hA);
        chk("hl_mul_b", {28'h0, mb[0]}, 32'hD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'h0, ov[0]}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy[0]}, 32'h0);
        chk("mid_rst_prod16", p[0], 32'h0);
        g_mon[0].sb.delete();
        g_mon[1].sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 8'h03, 8'h05);
        wait_idle(0);

        // Random operands with random sink backpressure on both variants
        rnd_rdy = 1'b1;
        fork
            while (rnd_rdy) begin
                @(posedge clk);
                #1;
                if (rnd_rdy) orr = 2'($urandom);
            end
        join_none
        repeat (40) begin
            send(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        orr = 2'b11;
        wait_idle(0);
        wait_idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul8_seq_sched.md
# mul8_seq_sched

Time-multiplexing scheduler that computes an 8x8 product using one shared 4x4 multiplier core instead of four parallel cores. The block captures a pair of 8-bit operands through a valid/ready handshake. It presents the four nibble pairs to the external core on successive cycles, in the order LL, LH, HL, HH, and accumulates the shifted partial products into a 16-bit result. It sits between an operand source and a result sink, beside one approximate 4x4 core, and is the area-reduced alternative to the fully parallel 8x8 composition.

## Interface
- TRUNC_LL, default 0: when 1, skip the LL step and treat the LL contribution as 0. This gives a 3-step, approximate variant.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  block can accept operands.
- a  in  8  multiplicand.
- b  in  8  multiplier.
- mul_a  out  4  nibble driven to the shared core's a input.
- mul_b  out  4  nibble driven to the shared core's b input.
- mul_en  out  1  core enable; high only in product steps.
- mul_prod  in  8  core product, combinational from mul_a and mul_b.
- out_valid  out  1  result is valid.
- out_ready  in  1  sink accepts the result.
- prod16  out  16  accumulated product.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, S_LL, S_LH, S_HL, S_HH, DONE.
- Accept happens when in_valid && in_ready. On accept:
  - a and b are registered into ah/al and bh/bl.
  - The accumulator is cleared.
  - Next state is S_LL, or S_LH if TRUNC_LL=1.
- Nibble selection per state:
  - S_LL: mul_a = al, mul_b = bl.
  - S_LH: mul_a = al, mul_b = bh.
  - S_HL: mul_a = ah, mul_b = bl.
  - S_HH: mul_a = ah, mul_b = bh.
  - IDLE and DONE: mul_a = mul_b = 0, mul_en = 0.
- Accumulation, sampled at the end of each step:
  - S_LL: acc += mul_prod.
  - S_LH and S_HL: acc += mul_prod << 4.
  - S_HH: acc += mul_prod << 8.
- All arithmetic is 16-bit modulo 2^16. This matters because an approximate core may return up to 0xFF, so the sum can exceed 16 bits and must wrap silently.
- S_HH always transitions to DONE. prod16 is driven from acc.
- In DONE:
  - out_valid = 1.
  - prod16 is held stable until out_ready.
  - With out_ready = 1: if in_valid is also 1, a new accept occurs in the same cycle (back-to-back); otherwise the next state is IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational.
- Operands are never re-sampled mid-computation. Changes on a, b after accept are ignored.
- Reset, asserted at any time (including mid-step or while out_valid is high):
  - state → IDLE, acc → 0, operand registers → 0.
  - Any pending result is discarded.

## Timing
- Reset values:
  - in_ready = 1, busy = 0.
  - out_valid = 0, prod16 = 0x0000.
  - mul_a = mul_b = 0, mul_en = 0.
- For an accept in cycle t:
  - TRUNC_LL=0: steps occupy t+1..t+4; out_valid is first high in cycle t+5. Latency is 5 cycles.
  - TRUNC_LL=1: steps occupy t+1..t+3; out_valid is first high in t+4.
- Throughput with out_ready held high:
  - TRUNC_LL=0: one result per 5 cycles.
  - TRUNC_LL=1: one result per 4 cycles.
  - DONE and accept overlap, so there is no dead IDLE cycle.
- mul_prod is used only in the cycle its nibbles are driven. The core's combinational path must close within one clock.
- in_valid without in_ready is held by the source (standard valid/ready). The block drops nothing.

## Test plan
- Core modelled exact, TRUNC_LL=0, a=0xFF, b=0xFF accepted at cycle t:
  - prod16 = 0xFE01 with out_valid first high at t+5.
  - mul_a/mul_b sequence at t+1..t+4 is (F,F),(F,F),(F,F),(F,F).
- Exact core, a=0x12, b=0x34:
  - mul_a/mul_b sequence is (2,4),(2,3),(1,4),(1,3).
  - prod16 = 0x03A8.
- TRUNC_LL=1, exact core, a=0x0F, b=0x0F:
  - Only 3 mul_en cycles occur.
  - prod16 = 0x0000, out_valid at t+4.
- Core forced to return 0xFF, any operands: prod16 = 0x1FDF (0x11FDF wrapped).
- Backpressure:
  - With out_ready low for 3 DONE cycles, prod16 and out_valid are stable and in_ready = 0.
  - Then out_ready = 1 with in_valid = 1 yields a same-cycle accept; the next result appears 5 cycles later.
- Reset mid-op: rst_n low during S_HL gives immediate out_valid = 0, busy = 0, prod16 = 0. A fresh a=0x03, b=0x05 after release yields 0x000F.
